// File: rtl/div_ctrl.sv
// div_ctrl: EX-stage front end for the iterative divider. Issues DIV/DIVU, stalls the
// pipeline until the divider answers, then holds {HI,LO} until EX advances.
module div_ctrl #(
  parameter int unsigned TIMEOUT      = 48,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_req_i,
  input  logic        div_signed_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic        flush_i,
  input  logic        ex_advance_i,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        signed_div_o,
  output logic [31:0] div_opdata1_o,
  output logic [31:0] div_opdata2_o,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic        stallreq_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_timeout_o
);

  localparam int unsigned CNT_MAX = (TIMEOUT > DRAIN_CYCLES) ? TIMEOUT : DRAIN_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_DRAIN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;   // busy-cycle count in S_BUSY, drain length in S_DRAIN
  logic             signed_q, signed_d;
  logic [31:0]      op1_q, op1_d;
  logic [31:0]      op2_q, op2_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             timeout_q, timeout_d;
  logic             abort;
  logic             timeout_hit;

  // A flush kills anything except an empty idle cycle; a stuck divider is treated the same way.
  assign abort       = flush_i & ((state_q != S_IDLE) | div_req_i);
  assign timeout_hit = (state_q == S_BUSY) & ~div_ready_i & (cnt_q == TIMEOUT_LAST);

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    signed_d   = signed_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    timeout_d  = timeout_q | timeout_hit;
    stallreq_o = 1'b0;

    if (abort || timeout_hit) begin
      state_d = S_DRAIN;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (div_req_i) begin
            signed_d   = div_signed_i;
            op1_d      = reg1_i;
            op2_d      = reg2_i;
            cnt_d      = '0;
            stallreq_o = 1'b1;
            state_d    = S_BUSY;
          end
        end
        S_BUSY: begin
          stallreq_o = 1'b1;
          if (div_ready_i) begin
            hi_d    = div_result_i[63:32];
            lo_d    = div_result_i[31:0];
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          // The request stays high while EX is stalled downstream; only advancing releases us.
          if (ex_advance_i) state_d = S_IDLE;
        end
        S_DRAIN: begin
          if (cnt_q == DRAIN_LAST) state_d = S_IDLE;
          else                     cnt_d   = cnt_q + 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      signed_q  <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      signed_q  <= signed_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      timeout_q <= timeout_d;
    end
  end

  assign div_start_o   = (state_q == S_BUSY);
  assign div_annul_o   = (state_q == S_DRAIN);
  assign whilo_o       = (state_q == S_DONE);
  assign signed_div_o  = signed_q;
  assign div_opdata1_o = op1_q;
  assign div_opdata2_o = op2_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;
  assign div_timeout_o = timeout_q;

endmodule
